// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryption, one inverse round per clock.
// The key schedule runs forward to round key 10, then is unwound in place during the rounds.
module aes_decrypt #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         busy,
   output logic         ready
);
   localparam logic [2:0] IDLE = 3'd0, EXPAND = 3'd1, ARK0 = 3'd2, ROUND = 3'd3, DONE = 3'd4;
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [0:2047] ISBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   localparam logic [0:127] RCON = 128'h0001020408102040801b360000000000;
   // InvMixColumns coefficients for row 0; later rows are rotations of it
   localparam logic [0:15] IMK = 16'hebd9;

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] isb(input logic [7:0] x);
      return ISBOX[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      return RCON[{i, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
   endfunction

   function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3;
      w3 = k[31:0] ^ k[63:32];
      return {k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0}, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], w3};
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] b2, b4, b8;
      b2 = xt(b);
      b4 = xt(b2);
      b8 = xt(b4);
      return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
   endfunction

   // byte (row r, column c) sits at index 4c+r, MSB first
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = isb(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               o[127-8*(4*c+i) -: 8] ^= gm(s[127-8*(4*c+j) -: 8], IMK[4*((j-i+4)%4) +: 4]);
      return o;
   endfunction

   logic [2:0]   fsm;
   logic [3:0]   cnt;
   logic [127:0] st, key_q, rk, s;

   assign rk = inv_expand(key_q, rcon(4'(ROUNDS + 1) - cnt));
   assign s  = inv_shift_sub(st) ^ rk;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         fsm       <= IDLE;
         cnt       <= '0;
         st        <= '0;
         key_q     <= '0;
         plaintext <= '0;
         busy      <= 1'b0;
         ready     <= 1'b0;
      end else case (fsm)
         EXPAND: begin
            key_q <= fwd_expand(key_q, rcon(cnt));
            cnt   <= cnt + 4'd1;
            if (cnt == 4'(ROUNDS)) fsm <= ARK0;
         end
         ARK0: begin
            st  <= st ^ key_q;
            cnt <= 4'd1;
            fsm <= ROUND;
         end
         ROUND: begin
            key_q <= rk;
            cnt   <= cnt + 4'd1;
            st    <= (cnt == 4'(ROUNDS)) ? s : inv_mix(s);
            if (cnt == 4'(ROUNDS)) begin
               plaintext <= s;
               ready     <= 1'b1;
               busy      <= 1'b0;
               fsm       <= DONE;
            end
         end
         default: if (start) begin
            st    <= ciphertext;
            key_q <= key;
            cnt   <= 4'd1;
            busy  <= 1'b1;
            ready <= 1'b0;
            fsm   <= EXPAND;
         end
      endcase
endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: scoreboard bench for aes_decrypt using FIPS-197 vectors.
module tb_aes_decrypt;
   logic         clk = 1'b0, reset = 1'b0, start = 1'b0, busy, ready;
   logic [127:0] ciphertext = '0, key = '0, plaintext;
   int           n_err = 0, n_chk = 0;
   logic [127:0] exp_q [$];

   localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_RK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_decrypt dut (.clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext),
                    .key(key), .plaintext(plaintext), .busy(busy), .ready(ready));

   always #5 clk = ~clk;

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // inputs are scrambled right after the accepting edge to prove they were latched
   task automatic issue(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
      @(negedge clk);
      start = 1'b1;
      ciphertext = c;
      key = k;
      exp_q.push_back(p);
      @(negedge clk);
      start = 1'b0;
      ciphertext = rnd();
      key = rnd();
   endtask

   task automatic run(input string tag, input logic [127:0] rk, input int pa, input int pb);
      int n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
         start = (n == pa || n == pb);
         if (start) begin
            ciphertext = rnd();
            key = rnd();
         end
         if (n == 1) check({tag, " busy"}, 128'(busy), 128'(1));
         if (n == 10) check({tag, " round key 10"}, dut.key_q, rk);
      end
      start = 1'b0;
      check({tag, " latency"}, 128'(n), 128'(21));
      check({tag, " plaintext"}, plaintext, exp_q.size() != 0 ? exp_q.pop_front() : 128'hx);
      check({tag, " busy at done"}, 128'(busy), 128'(0));
   endtask

   initial begin
      #1;
      check("reset plaintext", plaintext, 128'h0);
      check("reset busy", 128'(busy), 128'(0));
      check("reset ready", 128'(ready), 128'(0));
      @(negedge clk);
      reset = 1'b1;

      issue(C1_C, C1_K, C1_P);
      run("c1", C1_RK, 0, 0);
      repeat (3) @(negedge clk);
      check("done hold ready", 128'(ready), 128'(1));
      check("done hold plaintext", plaintext, C1_P);

      issue(B_C, B_K, B_P);
      run("b busy-start", B_RK, 5, 15);

      issue(C1_C, C1_K, C1_P);
      check("b2b ready drop", 128'(ready), 128'(0));
      check("b2b old plaintext", plaintext, B_P);
      run("b2b", C1_RK, 0, 0);

      issue(B_C, B_K, B_P);
      repeat (11) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort busy", 128'(busy), 128'(0));
      check("abort ready", 128'(ready), 128'(0));
      check("abort plaintext", plaintext, 128'h0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("idle busy", 128'(busy), 128'(0));
      check("idle ready", 128'(ready), 128'(0));

      issue(C1_C, C1_K, C1_P);
      run("post reset", C1_RK, 0, 0);
      check("scoreboard empty", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/aes_decrypt.md
Name: aes_decrypt

Overview:
- Iterative AES-128 decryption core, the inverse of the team's iterative encryption core. Recovers the 128-bit plaintext from a 128-bit ciphertext and the same 128-bit cipher key.
- Executes one inverse round per clock. The last round key is derived on-chip by running the forward key schedule. Round keys are then regenerated in reverse order with the inverse key schedule, so no round-key RAM is needed.
- Sits beside the encryption core in the password-vault datapath and is driven by the same controller.

Parameters:
- ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- ciphertext  input  128  block to decrypt; byte 0 = bits [127:120]
- key  input  128  cipher key (same byte order)
- plaintext  output  128  registered result
- busy  output  1  high from the accepted start until result valid
- ready  output  1  high while plaintext is valid

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, plaintext=0, busy=0, ready=0, round counter=0, internal state and key registers=0.
  - Reset asserted mid-operation aborts immediately. No partial result is ever flagged ready.
- FSM states: IDLE, EXPAND, ARK0, ROUND, DONE.
- IDLE / DONE:
  - If start=1 at the edge: latch ciphertext into the state register and key into the key register.
  - Set cnt=1, busy=1, ready=0, go to EXPAND.
  - In DONE with start=0: hold plaintext and ready=1 indefinitely.
- EXPAND (edges 1..10 after the accepting edge, cnt=1..10):
  - key_reg <= forward_expand(key_reg, rcon[cnt]).
  - After cnt=10, key_reg holds round key 10. Go to ARK0.
- ARK0 (1 cycle):
  - state <= state ^ key_reg.
  - Set cnt=1 and go to ROUND.
- ROUND (cnt=1..10, one per cycle). Combinationally, in order:
  - k = inverse_expand(key_reg, rcon[11-cnt]), which yields round key 10-cnt.
  - s = InvSubBytes(InvShiftRows(state)) ^ k.
  - If cnt<10: state <= InvMixColumns(s). If cnt=10: state <= s.
  - key_reg <= k.
- ROUND completion (cnt=10):
  - plaintext <= s, ready=1, busy=0, go to DONE.
- inverse_expand: w[i-4] = w[i] ^ w[i-1] for the last three words. The first word is w0 ^ SubWord(RotWord(new w3)) ^ rcon.
- Latency: with start accepted at edge 0, ready and plaintext are valid after edge 21 (10 EXPAND + 1 ARK0 + 10 ROUND). Throughput is one block per 21 cycles plus 1 cycle to restart.
- ciphertext and key may change after the accepting edge without affecting the result.
- start while busy=1 is ignored; no queueing or error.
- start asserted in DONE:
  - ready drops on the same edge, and plaintext keeps its old value until overwritten at completion.
  - Back-to-back operations need no idle cycle.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- S-box and inverse S-box are combinational lookup tables. InvMixColumns uses GF(2^8) multiplies by 09/0b/0d/0e with polynomial 0x11b.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, 1-cycle start -> exactly 21 cycles later ready=1, plaintext=00112233445566778899aabbccddeeff. Key register after EXPAND = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 Appendix B: key=2b7e151628aed2a6abf7158809cf4f3c, ciphertext=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734. Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start while busy: re-pulse start with different inputs at cycles 5 and 15 of the B.1 run -> result unchanged, ready still at cycle 21.
- Back-to-back: start in DONE with the C.1 vectors right after the B run -> ready falls on the accepting edge and rises 21 cycles later with the C.1 plaintext.
- Reset mid-operation: drive reset=0 asynchronously at cycle 12 -> busy, ready and plaintext are 0 immediately. After release with start held low, the core stays IDLE. A subsequent C.1 run completes correctly.
- Input hold: change ciphertext and key to random values the cycle after start -> output still matches the originally latched vector.
